game_flow_ctl: RTL

Frame-synchronous game sequencer that owns the final VGA output selection.
- Chooses between the game, win and lose streams.
- Gates game logic with a run enable.
- Holds end screens for a fixed number of frames and issues a restart pulse.
- Sits between game_state and the output mux and stream-select logic; screen changes only at frame boundaries so no frame is torn.

---
 rtl/game_pkg.sv | 23 ++
 rtl/game_flow_ctl_if.sv | 24 ++
 rtl/rise_detect.sv | 21 ++
 rtl/game_flow_ctl.sv | 133 +++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state/screen types and default frame constants for game_flow_ctl
package game_pkg;

    typedef enum logic [2:0] {
        READY     = 3'd0,
        START     = 3'd1,
        PLAY      = 3'd2,
        WIN_HOLD  = 3'd3,
        LOSE_HOLD = 3'd4,
        RESTART   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        SCR_GAME = 2'd0,
        SCR_WIN  = 2'd1,
        SCR_LOSE = 2'd2
    } screen_t;

    localparam int DEF_START_HOLD_FRAMES = 60;
    localparam int DEF_END_HOLD_FRAMES   = 180;
    localparam int DEF_CNT_W             = 8;

endpackage

// File: rtl/game_flow_ctl_if.sv
// rtl/game_flow_ctl_if.sv - signal bundle between the game logic / timing chain and game_flow_ctl
interface game_flow_ctl_if;

    logic       vblnk_in;
    logic       game_won;
    logic       game_lost;
    logic       button_shoot;
    logic [1:0] screen_sel;
    logic       game_run;
    logic       game_restart;
    logic       frame_tick;
    logic [2:0] state_dbg;

    modport master (
        output vblnk_in, game_won, game_lost, button_shoot,
        input  screen_sel, game_run, game_restart, frame_tick, state_dbg
    );

    modport slave (
        input  vblnk_in, game_won, game_lost, button_shoot,
        output screen_sel, game_run, game_restart, frame_tick, state_dbg
    );

endinterface

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - registered one-cycle pulse on a 0->1 transition of a sampled level
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic pulse
);

    logic d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q   <= 1'b0;
            pulse <= 1'b0;
        end else begin
            d_q   <= d;
            pulse <= d & ~d_q;
        end
    end

endmodule

// File: rtl/game_flow_ctl.sv
// rtl/game_flow_ctl.sv - frame-synchronous game sequencer and screen select (option: GAME_FLOW_AUTO_RESTART_EN)
module game_flow_ctl
    import game_pkg::*;
#(
    parameter int START_HOLD_FRAMES = DEF_START_HOLD_FRAMES,
    parameter int END_HOLD_FRAMES   = DEF_END_HOLD_FRAMES,
    parameter int CNT_W             = DEF_CNT_W
) (
    input  logic            clk,
    input  logic            rst_n,
    game_flow_ctl_if.slave  bus
);

    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_HOLD_FRAMES - 1);
    localparam logic [CNT_W-1:0] END_SAT    = CNT_W'(END_HOLD_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic             frame_tick;
    logic             shoot_edge;
    state_t           state;
    screen_t          screen_q;
    logic             run_q;
    logic             restart_q;
    logic             pending;
    logic             pending_lose;
    logic [CNT_W-1:0] frame_cnt;
    logic             end_sat;
    logic             auto_restart;

    rise_detect u_vblnk_rise (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.vblnk_in),
        .pulse (frame_tick)
    );

    rise_detect u_shoot_rise (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.button_shoot),
        .pulse (shoot_edge)
    );

    assign end_sat = (frame_cnt == END_SAT);

    // Auto restart fires on the tick that takes the counter to saturation.
`ifdef GAME_FLOW_AUTO_RESTART_EN
    assign auto_restart = (frame_cnt == (END_SAT - CNT_ONE));
`else
    assign auto_restart = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= READY;
            screen_q     <= SCR_GAME;
            run_q        <= 1'b0;
            restart_q    <= 1'b0;
            pending      <= 1'b0;
            pending_lose <= 1'b0;
            frame_cnt    <= '0;
        end else begin
            restart_q <= 1'b0;
            case (state)
                READY: begin
                    run_q <= 1'b0;
                    if (shoot_edge) begin
                        state     <= START;
                        frame_cnt <= '0;
                    end
                end
                START: begin
                    if (frame_tick) begin
                        screen_q <= SCR_GAME;
                        if (frame_cnt == START_LAST) begin
                            state <= PLAY;
                            run_q <= 1'b1;
                        end else begin
                            frame_cnt <= frame_cnt + CNT_ONE;
                        end
                    end
                end
                PLAY: begin
                    // An event seen in the same cycle as a tick only becomes pending, so it waits a frame.
                    if (frame_tick && pending) begin
                        state     <= pending_lose ? LOSE_HOLD : WIN_HOLD;
                        screen_q  <= pending_lose ? SCR_LOSE : SCR_WIN;
                        frame_cnt <= '0;
                    end else if (bus.game_won || bus.game_lost) begin
                        pending      <= 1'b1;
                        pending_lose <= pending_lose | bus.game_lost;
                        run_q        <= 1'b0;
                    end
                end
                WIN_HOLD, LOSE_HOLD: begin
                    if (shoot_edge && end_sat) begin
                        state     <= RESTART;
                        restart_q <= 1'b1;
                    end else if (frame_tick && !end_sat) begin
                        frame_cnt <= frame_cnt + CNT_ONE;
                        if (auto_restart) begin
                            state     <= RESTART;
                            restart_q <= 1'b1;
                        end
                    end
                end
                RESTART: begin
                    state        <= START;
                    frame_cnt    <= '0;
                    pending      <= 1'b0;
                    pending_lose <= 1'b0;
                    if (frame_tick) begin
                        screen_q <= SCR_GAME;
                    end
                end
                default: begin
                    state        <= READY;
                    run_q        <= 1'b0;
                    frame_cnt    <= '0;
                    pending      <= 1'b0;
                    pending_lose <= 1'b0;
                end
            endcase
        end
    end

    assign bus.screen_sel   = screen_q;
    assign bus.game_run     = run_q;
    assign bus.game_restart = restart_q;
    assign bus.frame_tick   = frame_tick;
    assign bus.state_dbg    = state;

endmodule
